// File: rtl/multi_core_data_memory_if.sv
// rtl/multi_core_data_memory_if.sv - processor and host port bundle of the banked data memory
interface multi_core_data_memory_if #(
  parameter int REG_WIDTH           = 12,
  parameter int CORE_COUNT          = 4,
  parameter int DATA_MEM_ADDR_WIDTH = 12,
  parameter int BANK_SEL_WIDTH      = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1
);
  logic                                      start;
  logic                                      done;
  logic [DATA_MEM_ADDR_WIDTH-1:0]            dataMemAddr;
  logic                                      DataMemWrEn;
  logic [REG_WIDTH*CORE_COUNT-1:0]           ProcessorDataOut;
  logic [REG_WIDTH*CORE_COUNT-1:0]           ProcessorDataIn;
  logic                                      hostReq;
  logic                                      hostWe;
  logic [BANK_SEL_WIDTH+DATA_MEM_ADDR_WIDTH-1:0] hostAddr;
  logic [REG_WIDTH-1:0]                      hostWdata;
  logic [REG_WIDTH-1:0]                      hostRdata;
  logic                                      hostAck;
  logic                                      procMode;

  modport master (
    output start, done, dataMemAddr, DataMemWrEn, ProcessorDataOut,
    output hostReq, hostWe, hostAddr, hostWdata,
    input  ProcessorDataIn, hostRdata, hostAck, procMode
  );

  modport slave (
    input  start, done, dataMemAddr, DataMemWrEn, ProcessorDataOut,
    input  hostReq, hostWe, hostAddr, hostWdata,
    output ProcessorDataIn, hostRdata, hostAck, procMode
  );
endinterface

// File: rtl/multi_core_data_memory.sv
// rtl/multi_core_data_memory.sv - per-core data memory banks shared between processor and host port
// Optional DATA_MEM_WR_BYPASS_EN: write-first processor lane reads (default read-first).
module multi_core_data_memory #(
  parameter int REG_WIDTH           = 12,
  parameter int CORE_COUNT          = 4,
  parameter int DATA_MEM_ADDR_WIDTH = 12,
  parameter int BANK_SEL_WIDTH      = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1
) (
  input logic                    clk,
  input logic                    rstN,
  multi_core_data_memory_if.slave bus
);
  localparam int DEPTH = 2 ** DATA_MEM_ADDR_WIDTH;

  typedef enum logic {ST_HOST, ST_PROC} state_t;

  state_t                           r_state;
  logic                             r_host_ack;
  logic [REG_WIDTH-1:0]             r_host_rdata;
  logic [REG_WIDTH*CORE_COUNT-1:0]  w_proc_rd;
  logic [REG_WIDTH-1:0]             w_host_word [CORE_COUNT];
  logic [REG_WIDTH-1:0]             w_host_rd;
  logic [BANK_SEL_WIDTH-1:0]        w_bank;
  logic [DATA_MEM_ADDR_WIDTH-1:0]   w_word;
  logic                             w_bank_ok;
  logic                             w_host_accept;
  logic                             w_host_we;
  logic                             w_proc_we;

  assign w_bank    = bus.hostAddr[BANK_SEL_WIDTH+DATA_MEM_ADDR_WIDTH-1 -: BANK_SEL_WIDTH];
  assign w_word    = bus.hostAddr[DATA_MEM_ADDR_WIDTH-1:0];
  assign w_bank_ok = int'(w_bank) < CORE_COUNT;

  // A held request re-arms only once the previous ack has dropped.
  assign w_host_accept = (r_state == ST_HOST) && bus.hostReq && !r_host_ack;
  // Writes are gated by rstN so nothing lands while reset is held at an edge.
  assign w_host_we     = w_host_accept && bus.hostWe && w_bank_ok && rstN;
  assign w_proc_we     = (r_state == ST_PROC) && bus.DataMemWrEn && rstN;

  for (genvar g = 0; g < CORE_COUNT; g++) begin : g_bank
    logic [REG_WIDTH-1:0]           r_mem [DEPTH];
    logic [REG_WIDTH-1:0]           r_lane;
    logic                           w_we;
    logic [DATA_MEM_ADDR_WIDTH-1:0] w_waddr;
    logic [REG_WIDTH-1:0]           w_wdata;

    assign w_we    = w_proc_we || (w_host_we && (w_bank == BANK_SEL_WIDTH'(g)));
    assign w_waddr = w_proc_we ? bus.dataMemAddr : w_word;
    assign w_wdata = w_proc_we ? bus.ProcessorDataOut[g*REG_WIDTH +: REG_WIDTH] : bus.hostWdata;

    always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
        r_lane <= '0;
      end else begin
`ifdef DATA_MEM_WR_BYPASS_EN
        if (w_we && (w_waddr == bus.dataMemAddr)) r_lane <= w_wdata;
        else                                      r_lane <= r_mem[bus.dataMemAddr];
`else
        r_lane <= r_mem[bus.dataMemAddr];
`endif
      end
    end

    assign w_host_word[g]                        = r_mem[w_word];
    assign w_proc_rd[g*REG_WIDTH +: REG_WIDTH]   = r_lane;
  end

  // Out-of-range bank selects read as zero.
  always_comb begin
    w_host_rd = '0;
    for (int b = 0; b < CORE_COUNT; b++) begin
      if (int'(w_bank) == b) w_host_rd = w_host_word[b];
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state      <= ST_HOST;
      r_host_ack   <= 1'b0;
      r_host_rdata <= '0;
    end else begin
      case (r_state)
        ST_HOST: if (bus.start && !bus.done) r_state <= ST_PROC;
        ST_PROC: if (bus.done)               r_state <= ST_HOST;
        default:                             r_state <= ST_HOST;
      endcase
      r_host_ack <= w_host_accept;
      if (w_host_accept && !bus.hostWe) r_host_rdata <= w_host_rd;
    end
  end

  assign bus.ProcessorDataIn = w_proc_rd;
  assign bus.hostRdata       = r_host_rdata;
  assign bus.hostAck         = r_host_ack;
  assign bus.procMode        = (r_state == ST_PROC);
endmodule

// File: tb/tb_multi_core_data_memory.sv
// tb/tb_multi_core_data_memory.sv - directed bench for multi_core_data_memory
module tb_multi_core_data_memory;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [11:0] rd;

  always #5 clk = ~clk;

  multi_core_data_memory_if bus ();

  multi_core_data_memory dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Presents one host request at a negedge; ack is expected exactly one cycle later.
  task automatic host_xfer(input logic we, input logic [1:0] bank, input logic [11:0] word,
                           input logic [11:0] wd, output logic [11:0] rdo);
    @(negedge clk);
    bus.hostReq   = 1'b1;
    bus.hostWe    = we;
    bus.hostAddr  = {bank, word};
    bus.hostWdata = wd;
    @(negedge clk);
    chk("host_ack", 48'(bus.hostAck), 48'd1);
    rdo = bus.hostRdata;
    bus.hostReq = 1'b0;
  endtask

  initial begin
    bus.start = 0; bus.done = 0; bus.dataMemAddr = '0; bus.DataMemWrEn = 0;
    bus.ProcessorDataOut = '0; bus.hostReq = 0; bus.hostWe = 0; bus.hostAddr = '0; bus.hostWdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_pdin",  48'(bus.ProcessorDataIn), 48'd0);
    chk("rst_rdata", 48'(bus.hostRdata), 48'd0);
    chk("rst_ack",   48'(bus.hostAck), 48'd0);
    chk("rst_mode",  48'(bus.procMode), 48'd0);
    rstN = 1'b1;

    host_xfer(1'b1, 2'd2, 12'h005, 12'hABC, rd);
    host_xfer(1'b0, 2'd2, 12'h005, 12'h000, rd);
    chk("host_rd_abc", 48'(rd), 48'hABC);
    @(negedge clk);
    chk("ack_drop", 48'(bus.hostAck), 48'd0);

    for (int b = 0; b < 4; b++) host_xfer(1'b1, 2'(b), 12'h010, 12'(b + 1), rd);

    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("proc_mode", 48'(bus.procMode), 48'd1);
    bus.dataMemAddr = 12'h010;
    @(negedge clk);
    chk("proc_rd_010", 48'(bus.ProcessorDataIn), {12'd4, 12'd3, 12'd2, 12'd1});

    bus.dataMemAddr = 12'h020;
    bus.DataMemWrEn = 1'b1;
    bus.ProcessorDataOut = {12'h444, 12'h333, 12'h222, 12'h111};
    @(negedge clk);
    bus.DataMemWrEn = 1'b0;

    bus.hostReq = 1'b1; bus.hostWe = 1'b0; bus.hostAddr = {2'd3, 12'h020};
    repeat (3) begin
      @(negedge clk);
      chk("no_ack_proc", 48'(bus.hostAck), 48'd0);
    end
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    chk("mode_after_done", 48'(bus.procMode), 48'd0);
    chk("ack_done_p1", 48'(bus.hostAck), 48'd0);
    @(negedge clk);
    chk("ack_done_p2", 48'(bus.hostAck), 48'd1);
    chk("rd_b3_020", 48'(bus.hostRdata), 48'h444);
    bus.hostReq = 1'b0;

    @(negedge clk);
    bus.DataMemWrEn = 1'b1;
    bus.ProcessorDataOut = {4{12'hFFF}};
    @(negedge clk);
    bus.DataMemWrEn = 1'b0;
    @(negedge clk);
    chk("host_mode_wren_lanes", 48'(bus.ProcessorDataIn), {12'h444, 12'h333, 12'h222, 12'h111});
    host_xfer(1'b0, 2'd3, 12'h020, 12'h000, rd);
    chk("host_mode_wren_b3", 48'(rd), 48'h444);

    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dataMemAddr = 12'h030;
    bus.DataMemWrEn = 1'b1;
    bus.ProcessorDataOut = {4{12'h0AA}};
    @(negedge clk);
    bus.ProcessorDataOut = {4{12'h0BB}};
    @(negedge clk);
`ifdef DATA_MEM_WR_BYPASS_EN
    chk("same_cycle_rw", 48'(bus.ProcessorDataIn), {4{12'h0BB}});
`else
    chk("same_cycle_rw", 48'(bus.ProcessorDataIn), {4{12'h0AA}});
`endif
    bus.DataMemWrEn = 1'b0;
    @(negedge clk);
    chk("after_write_030", 48'(bus.ProcessorDataIn), {4{12'h0BB}});
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    chk("mode_host_again", 48'(bus.procMode), 48'd0);

    @(negedge clk);
    bus.hostReq = 1'b1; bus.hostWe = 1'b0; bus.hostAddr = {2'd2, 12'h005};
    rstN = 1'b0;
    @(negedge clk);
    chk("rst_mid_ack",   48'(bus.hostAck), 48'd0);
    chk("rst_mid_rdata", 48'(bus.hostRdata), 48'd0);
    chk("rst_mid_pdin",  48'(bus.ProcessorDataIn), 48'd0);
    chk("rst_mid_mode",  48'(bus.procMode), 48'd0);
    bus.hostReq = 1'b0;
    rstN = 1'b1;
    @(negedge clk);
    chk("rst_mid_ack2", 48'(bus.hostAck), 48'd0);
    host_xfer(1'b0, 2'd2, 12'h005, 12'h000, rd);
    chk("keep_b2_005", 48'(rd), 48'hABC);
    host_xfer(1'b0, 2'd0, 12'h010, 12'h000, rd);
    chk("keep_b0_010", 48'(rd), 48'h001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
